// File: rtl/layer2_argmax_if.sv
// Handshake bundle between the layer-2 node array, the argmax block and its consumer.
// master = node array / consumer side, slave = layer2_argmax.
interface layer2_argmax_if #(
   parameter int NUM_NODES = 8
);
   localparam int IDX_W = $clog2(NUM_NODES);

   logic                   in_valid;
   logic [8*NUM_NODES-1:0] n_bus;
   logic [IDX_W-1:0]       class_idx;
   logic [7:0]             class_val;
   logic                   out_valid;
   logic                   out_ready;
   logic                   busy;
   logic [7:0]             ovf_cnt;

   modport master (
      output in_valid, n_bus, out_ready,
      input  class_idx, class_val, out_valid, busy, ovf_cnt
   );

   modport slave (
      input  in_valid, n_bus, out_ready,
      output class_idx, class_val, out_valid, busy, ovf_cnt
   );
endinterface

// File: rtl/layer2_argmax.sv
// Sequential argmax over the layer-2 node outputs, one node per clock.
// Define LAYER2_ARGMAX_OVF_CNT_EN to build the dropped-frame counter (ovf_cnt), otherwise it reads 0.
module layer2_argmax #(
   parameter int NUM_NODES    = 8,
   parameter int NODE_LATENCY = 3
) (
   input logic            clk,
   input logic            reset,
   layer2_argmax_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_NODES);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NUM_NODES - 1);

   logic [NODE_LATENCY-1:0] vld_dly;
   logic                    dv;
   logic [1:0]              state;
   logic [IDX_W-1:0]        k;
   logic [7:0]              frame [NUM_NODES];
   logic [7:0]              best_val;
   logic [IDX_W-1:0]        best_idx;
   logic [7:0]              node_k;
   logic                    take;
   logic [7:0]              next_val;
   logic [IDX_W-1:0]        next_idx;
   logic [IDX_W-1:0]        result_idx;
   logic [7:0]              result_val;
   logic                    result_vld;

   assign dv     = vld_dly[NODE_LATENCY-1];
   assign node_k = frame[k];

   // Node 0 seeds the running best; later nodes win only on a strictly larger value,
   // so ties resolve to the lowest index.
   assign take     = (k == '0) || (node_k > best_val);
   assign next_val = take ? node_k : best_val;
   assign next_idx = take ? k : best_idx;

   // Delay line: in_valid -> dv, aligned with n_bus carrying that frame
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_dly <= '0;
      end else begin
         vld_dly[0] <= bus.in_valid;
         for (int i = 1; i < NODE_LATENCY; i++)
            vld_dly[i] <= vld_dly[i-1];
      end
   end

   // Frame capture: written only when a frame is accepted
   always_ff @(posedge clk) begin
      if (state == IDLE && dv) begin
         for (int i = 0; i < NUM_NODES; i++)
            frame[i] <= bus.n_bus[8*i +: 8];
      end
   end

   // Control FSM and scan datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         k          <= '0;
         best_val   <= '0;
         best_idx   <= '0;
         result_idx <= '0;
         result_val <= '0;
         result_vld <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (dv) begin
                  k     <= '0;
                  state <= SCAN;
               end
            end
            SCAN: begin
               best_val <= next_val;
               best_idx <= next_idx;
               if (k == LAST_K) begin
                  result_idx <= next_idx;
                  result_val <= next_val;
                  result_vld <= 1'b1;
                  state      <= DONE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  result_vld <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LAYER2_ARGMAX_OVF_CNT_EN
   logic [7:0] ovf_q;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // A frame arriving while busy is lost; count it, saturating
   always_ff @(posedge clk) begin
      if (reset)
         ovf_q <= '0;
      else if (dv && state != IDLE)
         ovf_q <= sat_inc(ovf_q);
   end

   assign bus.ovf_cnt = ovf_q;
`else
   assign bus.ovf_cnt = 8'd0;
`endif

   assign bus.class_idx = result_idx;
   assign bus.class_val = result_val;
   assign bus.out_valid = result_vld;
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_layer2_argmax.sv
// Self-checking bench for layer2_argmax: directed frames plus randomized frames
// checked against a first-maximum reference model.
module tb_layer2_argmax;
   localparam int NN = 8;
   localparam int NL = 3;
   localparam int IW = $clog2(NN);

`ifdef LAYER2_ARGMAX_OVF_CNT_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   typedef int frame_t [NN];

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   layer2_argmax_if #(.NUM_NODES(NN)) bus ();

   layer2_argmax #(.NUM_NODES(NN), .NODE_LATENCY(NL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Reference: largest value, first position holding it
   function automatic void ref_argmax(input frame_t v, output int idx, output int val);
      int mx = 0;
      foreach (v[i]) if (v[i] > mx) mx = v[i];
      idx = -1;
      foreach (v[i]) if (idx < 0 && v[i] == mx) idx = i;
      val = mx;
   endfunction

   function automatic logic [8*NN-1:0] pack(input frame_t v);
      logic [8*NN-1:0] p;
      for (int i = 0; i < NN; i++) p[8*i +: 8] = 8'(v[i]);
      return p;
   endfunction

   function automatic int exp_ovf(input int drops);
      if (!OVF_EN) return 0;
      return (drops > 255) ? 255 : drops;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_frame(output frame_t v);
      for (int i = 0; i < NN; i++) v[i] = int'($urandom_range(127, 0));
   endtask

   // Presents one frame with in_valid for one cycle; returns one cycle later.
   task automatic pulse(input frame_t v);
      bus.n_bus    = pack(v);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(input int bound, output int cyc, output bit ok);
      cyc = 0;
      while (bus.out_valid !== 1'b1 && cyc < bound) begin
         tick();
         cyc++;
      end
      ok = (bus.out_valid === 1'b1);
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.n_bus    = '0;
      tick();
      tick();
      tests++;
      if (bus.class_idx !== '0 || bus.class_val !== 8'd0) begin
         fails++;
         $display("FAIL reset_class: idx=%0d val=%0d, want 0/0", bus.class_idx, bus.class_val);
      end
      tests++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl: out_valid=%b busy=%b, want 0/0", bus.out_valid, bus.busy);
      end
      tests++;
      if (bus.ovf_cnt !== 8'd0) begin
         fails++;
         $display("FAIL reset_ovf: ovf_cnt=%0d, want 0", bus.ovf_cnt);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      frame_t f = '{5, 90, 12, 127, 3, 0, 64, 100};
      int cyc, ei, ev;
      bit ok;
      ref_argmax(f, ei, ev);
      bus.out_ready = 1'b1;
      pulse(f);
      tests++;
      if (bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL basic_idle_busy: busy=%b before capture, want 0", bus.busy);
      end
      wait_out(40, cyc, ok);
      tests++;
      if (!ok || cyc + 1 != NL + NN + 1) begin
         fails++;
         $display("FAIL basic_latency: out_valid after %0d cycles (seen=%b), want %0d", cyc + 1, ok, NL + NN + 1);
      end
      tests++;
      if (bus.class_idx !== IW'(ei) || bus.class_val !== 8'(ev) || ei != 3 || ev != 127) begin
         fails++;
         $display("FAIL basic_result: idx=%0d val=%0d, want 3/127", bus.class_idx, bus.class_val);
      end
      tests++;
      if (bus.busy !== 1'b1) begin
         fails++;
         $display("FAIL basic_busy_done: busy=%b, want 1", bus.busy);
      end
      tick();
      tests++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL basic_release: out_valid=%b busy=%b, want 0/0", bus.out_valid, bus.busy);
      end
   endtask

   task automatic test_tie_and_zero();
      frame_t fr [2];
      frame_t junk = '{127, 127, 127, 127, 127, 127, 127, 127};
      int cyc, ei, ev;
      bit ok;
      fr[0] = '{40, 127, 7, 127, 0, 0, 0, 127};
      fr[1] = '{0, 0, 0, 0, 0, 0, 0, 0};
      bus.out_ready = 1'b1;
      for (int t = 0; t < 2; t++) begin
         ref_argmax(fr[t], ei, ev);
         pulse(fr[t]);
         repeat (4) tick();
         bus.n_bus = pack(junk);
         wait_out(40, cyc, ok);
         tests++;
         if (!ok || bus.class_idx !== IW'(ei) || bus.class_val !== 8'(ev)) begin
            fails++;
            $display("FAIL tie_zero_%0d: seen=%b idx=%0d val=%0d, want %0d/%0d", t, ok, bus.class_idx, bus.class_val, ei, ev);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      frame_t f;
      int cyc, ei, ev;
      bit ok;
      int bad = 0;
      rand_frame(f);
      ref_argmax(f, ei, ev);
      bus.out_ready = 1'b0;
      pulse(f);
      wait_out(40, cyc, ok);
      for (int i = 0; i < 20; i++) begin
         tests++;
         if (bus.out_valid !== 1'b1 || bus.class_idx !== IW'(ei) || bus.class_val !== 8'(ev)) begin
            fails++;
            bad++;
            if (bad < 4)
               $display("FAIL bp_hold_%0d: out_valid=%b idx=%0d val=%0d, want 1/%0d/%0d", i, bus.out_valid, bus.class_idx, bus.class_val, ei, ev);
         end
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      tests++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL bp_release: out_valid=%b busy=%b, want 0/0", bus.out_valid, bus.busy);
      end
   endtask

   task automatic test_overflow();
      frame_t fa = '{10, 20, 30, 40, 50, 60, 70, 126};
      frame_t fb = '{127, 0, 0, 0, 0, 0, 0, 0};
      int cyc, ei, ev;
      bit ok;
      ref_argmax(fa, ei, ev);
      bus.out_ready = 1'b0;
      pulse(fa);
      repeat (3) tick();
      pulse(fb);
      wait_out(40, cyc, ok);
      tests++;
      if (!ok || bus.class_idx !== IW'(ei) || bus.class_val !== 8'(ev)) begin
         fails++;
         $display("FAIL ovf_first_result: idx=%0d val=%0d, want %0d/%0d", bus.class_idx, bus.class_val, ei, ev);
      end
      tests++;
      if (bus.ovf_cnt !== 8'(exp_ovf(1))) begin
         fails++;
         $display("FAIL ovf_one: ovf_cnt=%0d, want %0d", bus.ovf_cnt, exp_ovf(1));
      end
      bus.in_valid = 1'b1;
      repeat (300) tick();
      bus.in_valid = 1'b0;
      repeat (NL + 1) tick();
      tests++;
      if (bus.ovf_cnt !== 8'(exp_ovf(301))) begin
         fails++;
         $display("FAIL ovf_saturate: ovf_cnt=%0d, want %0d", bus.ovf_cnt, exp_ovf(301));
      end
      tests++;
      if (bus.out_valid !== 1'b1 || bus.class_idx !== IW'(ei) || bus.class_val !== 8'(ev)) begin
         fails++;
         $display("FAIL ovf_undisturbed: out_valid=%b idx=%0d val=%0d", bus.out_valid, bus.class_idx, bus.class_val);
      end
      bus.out_ready = 1'b1;
      tick();
   endtask

   task automatic test_reset_midscan();
      frame_t fa, fb, fc, fd;
      int cyc, ei, ev;
      bit ok;
      bit bad = 1'b0;
      rand_frame(fa);
      rand_frame(fb);
      rand_frame(fc);
      rand_frame(fd);
      bus.out_ready = 1'b1;
      pulse(fa);
      repeat (3) tick();
      pulse(fb);
      tick();
      pulse(fc);
      reset = 1'b1;
      tick();
      tests++;
      if (bus.class_idx !== '0 || bus.class_val !== 8'd0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ovf_cnt !== 8'd0) begin
         fails++;
         $display("FAIL midscan_reset: idx=%0d val=%0d out_valid=%b busy=%b ovf=%0d, want all 0",
                  bus.class_idx, bus.class_val, bus.out_valid, bus.busy, bus.ovf_cnt);
      end
      reset = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ovf_cnt !== 8'd0) bad = 1'b1;
         tick();
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL midscan_discard: activity after reset, out_valid=%b busy=%b ovf=%0d, want 0/0/0",
                  bus.out_valid, bus.busy, bus.ovf_cnt);
      end
      ref_argmax(fd, ei, ev);
      pulse(fd);
      wait_out(40, cyc, ok);
      tests++;
      if (!ok || bus.class_idx !== IW'(ei) || bus.class_val !== 8'(ev)) begin
         fails++;
         $display("FAIL midscan_fresh: seen=%b idx=%0d val=%0d, want %0d/%0d", ok, bus.class_idx, bus.class_val, ei, ev);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      frame_t f, junk;
      int cyc, ei, ev;
      bit ok;
      int results = 0;
      bus.out_ready = 1'b1;
      for (int n = 0; n < 10; n++) begin
         rand_frame(f);
         rand_frame(junk);
         ref_argmax(f, ei, ev);
         pulse(f);
         repeat (4) tick();
         bus.n_bus = pack(junk);
         wait_out(40, cyc, ok);
         if (ok) results++;
         tests++;
         if (!ok || bus.class_idx !== IW'(ei) || bus.class_val !== 8'(ev)) begin
            fails++;
            $display("FAIL b2b_frame_%0d: seen=%b idx=%0d val=%0d, want %0d/%0d", n, ok, bus.class_idx, bus.class_val, ei, ev);
         end
         tick();
      end
      tests++;
      if (results != 10 || bus.ovf_cnt !== 8'd0) begin
         fails++;
         $display("FAIL b2b_summary: results=%0d ovf=%0d, want 10/0", results, bus.ovf_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie_and_zero();
      test_backpressure();
      test_overflow();
      test_reset_midscan();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
